fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, issues word requests to instruction memory and holds the fetched word in the IF/ID register. The IF/ID register drives the 6-bit opcode into the main control decoder. The block also applies branch redirects, stalls and flushes from the decode/execute stages, and buffers one returned word when the pipeline is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: request valid. Held high with a stable `imem_addr` until `imem_ack`.
- `imem_addr`  out  32: word-aligned fetch address, bits [1:0] always 00.
- `imem_ack`  in  1: `imem_rdata` is valid this cycle. It may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32: fetched instruction word.
- `stall`  in  1: hazard stall. Freezes IF/ID and the PC.
- `branch_taken`  in  1: redirect request. Flushes IF/ID.
- `branch_target`  in  32: redirect address. Bits [1:0] are ignored and forced to 00.
- `ifid_valid`  out  1: IF/ID holds a real instruction.
- `ifid_instr`  out  32: IF/ID instruction. Reads 32'h0 (NOP) whenever `ifid_valid`=0.
- `ifid_pc4`  out  32: address of the IF/ID instruction + 4.
- `opcode`  out  6: `ifid_instr[31:26]`, wired to the control decoder `ins` input.

## Operation
- State registers:
  - `pc`: next address to fetch.
  - `buf_instr` / `buf_pc4`: one-entry skid buffer.
  - `state`: one of FETCH, WAIT, DRAIN.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack` with `stall`=0: load IF/ID with {rdata, pc+4}, set `ifid_valid`=1, `pc`<=`pc`+4, stay in FETCH.
  - On `imem_ack` with `stall`=1: capture {rdata, pc+4} into the buffer, `pc`<=`pc`+4, go to WAIT.
  - No ack and `stall`=0: `ifid_valid`<=0 (bubble). With `stall`=1, IF/ID holds.
- WAIT:
  - `imem_req`=0 and the buffer is full.
  - When `stall`=0: move the buffer into IF/ID, `ifid_valid`=1, go to FETCH.
- DRAIN:
  - Entered when a redirect hits while a request is outstanding with no ack in that cycle.
  - Keeps `imem_req`=1 with the old `imem_addr` until `imem_ack`.
  - Discards the returned data, then goes to FETCH at the already-updated `pc`.
  - `ifid_valid`=0 throughout DRAIN.
- Redirect (`branch_taken`=1, any state):
  - `pc`<={target[31:2],2'b00}.
  - IF/ID cleared (`ifid_valid`=0, `ifid_instr`=0, `ifid_pc4`=0).
  - Buffer discarded.
  - A same-cycle `imem_ack` is discarded.
  - Next state: FETCH if `state`=WAIT or an ack arrived, DRAIN if FETCH without ack, DRAIN if already in DRAIN without ack.
- Priority: `rst` > `branch_taken` > `stall`. A redirect during a stall still flushes.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, and `ifid_pc4` wraps the same way.

## Timing
- Reset cycle (`rst`=1 at an edge), values after that edge:
  - `pc`=`RESET_PC`, `state`=FETCH.
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc4`=0.
  - `imem_req`=0 while `rst` is high.
- `imem_req` first asserts in the first cycle with `rst`=0.
- Reset mid-request: the outstanding request is abandoned and any ack in a reset cycle is ignored. The memory model must tolerate `imem_req` dropping.
- Latency: `imem_ack` at edge N puts the word in IF/ID after edge N. `opcode` is valid in cycle N+1.
- Throughput: zero-wait memory (ack same cycle as req) gives one instruction per cycle.
- Stall release from WAIT: the buffered word enters IF/ID one edge after `stall` falls. FETCH resumes in the following cycle.
- Redirect: the first request to the target issues in the cycle after `branch_taken` (from FETCH-with-ack or WAIT), or in the cycle after the drain ack.
- `imem_addr` is a registered output from `pc` and is stable while `imem_req`=1 and no ack.

## Test plan
- **Reset and sequential fetch.** Reset with `RESET_PC`=0, zero-wait memory returning addr-based words -> `imem_addr` 0,4,8,C on consecutive cycles; `ifid_pc4` 4,8,C,10; `opcode` matches word[31:26] one cycle after each ack.
- **Wait states.** Memory acks every third cycle -> `imem_addr` holds for 3 cycles; `ifid_valid` pattern 0,0,1 repeating; no address skipped.
- **Stall with skid.** Assert `stall` for 4 cycles while ack arrives at addr 8 -> IF/ID keeps the addr-4 word; no request during WAIT; after release IF/ID = word@8 with `ifid_pc4`=C, then the fetch of C.
- **Branch with ack.** `branch_taken` with target 32'h0000_0103 in the same cycle as an ack -> data discarded, IF/ID cleared to 0, next `imem_addr`=32'h0000_0100.
- **Branch during outstanding request.** `branch_taken` while a request to 0x40 is outstanding (ack 2 cycles later) -> `imem_addr` stays 0x40 until ack, data discarded, then `imem_addr`=target; `ifid_valid`=0 throughout.
- **Wrap and reset mid-stall.** `RESET_PC`=FFFF_FFF8 -> fetch addresses F8, FC, then 0. Assert `rst` while in WAIT -> all outputs return to their reset values after the edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory,
// holds the IF/ID register and a one-entry skid buffer for stalled returns.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  opcode
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-state logic: redirect overrides everything, then per-state fetch/stall handling
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;

        if (branch_taken) begin
            pc_d        = {branch_target[31:2], 2'b00};
            valid_d     = 1'b0;
            instr_d     = 32'h0000_0000;
            pc4_d       = 32'h0000_0000;
            buf_instr_d = 32'h0000_0000;
            buf_pc4_d   = 32'h0000_0000;
            case (state_q)
                S_WAIT:  state_d = S_FETCH;
                S_FETCH: state_d = imem_ack ? S_FETCH : S_DRAIN;
                S_DRAIN: state_d = imem_ack ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_plus4_s;
                        if (stall) begin
                            buf_instr_d = imem_rdata;
                            buf_pc4_d   = pc_plus4_s;
                            state_d     = S_WAIT;
                        end else begin
                            valid_d = 1'b1;
                            instr_d = imem_rdata;
                            pc4_d   = pc_plus4_s;
                        end
                    end else if (!stall) begin
                        valid_d = 1'b0;
                        instr_d = 32'h0000_0000;
                    end else begin
                        valid_d = valid_q;
                    end
                end
                S_WAIT: begin
                    if (!stall) begin
                        valid_d = 1'b1;
                        instr_d = buf_instr_q;
                        pc4_d   = buf_pc4_q;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DRAIN: begin
                    // Returned word belongs to the abandoned path and is dropped
                    if (imem_ack) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end

        // The bus address only lags the PC while an abandoned request drains
        if (state_d == S_DRAIN) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            addr_q      <= {RESET_PC[31:2], 2'b00};
            buf_instr_q <= 32'h0000_0000;
            buf_pc4_q   <= 32'h0000_0000;
            valid_q     <= 1'b0;
            instr_q     <= 32'h0000_0000;
            pc4_q       <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
        end
    end

    assign imem_req   = !rst && (state_q != S_WAIT);
    assign imem_addr  = addr_q;
    assign ifid_valid = valid_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign opcode     = instr_q[31:26];

endmodule
